decoder_38_driver: RTL

Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a fixed-length output pulse, forming the receive end of the 8-to-3 priority-code path: a 3-bit code is accepted, decoded and its one-hot line driven high for a programmable number of cycles, followed by a programmable guard gap. It sits between the code source (encoder output or control FSM) and eight per-line select/strobe consumers. A saturating accept counter supports bring-up.

---
 rtl/decoder_38_pkg.sv | 22 ++
 rtl/onehot_decode_38.sv | 21 ++
 rtl/decoder_38_driver.sv | 129 ++++++++++++
 3 files changed

// File: rtl/decoder_38_pkg.sv
// Shared definitions for the 3-to-8 decoder driver.
// Holds the FSM state encoding, code/one-hot widths, the width of the
// internal hold/gap counters, and the onehot_of() helper.
package decoder_38_pkg;

  localparam int unsigned CODE_W   = 3;
  localparam int unsigned ONEHOT_W = 8;
  // Hold and gap counters only need to reach 254 (legal range is 1..255).
  localparam int unsigned CTR_W    = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StGap   = 2'd2
  } state_e;

  // Binary code to one-hot line select.
  function automatic logic [ONEHOT_W-1:0] onehot_of(input logic [CODE_W-1:0] code);
    return ONEHOT_W'(1) << code;
  endfunction

endpackage

// File: rtl/onehot_decode_38.sv
// Combinational 3-to-8 one-hot decoder with enable.
// Ports:
//   code_i   - binary code 0..7
//   en_i     - decode enable; output is all-zero when low
//   onehot_o - one-hot line select
module onehot_decode_38
  import decoder_38_pkg::*;
(
  input  logic [CODE_W-1:0]   code_i,
  input  logic                en_i,
  output logic [ONEHOT_W-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o = onehot_of(code_i);
    end
  end

endmodule

// File: rtl/decoder_38_driver.sv
// Registered 3-to-8 one-hot decoder with valid/ready input handshake.
// An accepted code drives its one-hot line for HOLD_CYCLES cycles, then the
// output sits at zero for GAP_CYCLES cycles before the block re-arms.
// Ports:
//   clk_i        - clock, all state updates on rising edge
//   rst_i        - synchronous active-high reset
//   en_i         - acceptance enable (affects in_ready_o only)
//   in_valid_i   - in_code_i is valid
//   in_code_i    - binary code to decode
//   in_ready_o   - block can accept a code this cycle (combinational)
//   out_onehot_o - registered one-hot output, nonzero only while driving
//   busy_o       - registered, high while driving or in the guard gap
//   done_o       - registered one-cycle pulse after the last drive cycle
//   accept_cnt_o - saturating count of accepted codes
module decoder_38_driver
  import decoder_38_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                in_valid_i,
  input  logic [CODE_W-1:0]   in_code_i,
  output logic                in_ready_o,
  output logic [ONEHOT_W-1:0] out_onehot_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    accept_cnt_o
);

  localparam logic [CTR_W-1:0] HoldLoad = CTR_W'(HOLD_CYCLES - 1);
  localparam logic [CTR_W-1:0] GapLoad  = (GAP_CYCLES > 0) ? CTR_W'(GAP_CYCLES - 1) : '0;
  localparam bit               HasGap   = (GAP_CYCLES > 0);

  state_e                state_q, state_d;
  logic [CTR_W-1:0]      hold_q, hold_d;
  logic [CTR_W-1:0]      gap_q, gap_d;
  logic [CODE_W-1:0]     code_q, code_d;
  logic [ONEHOT_W-1:0]   onehot_q, onehot_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  accept;

  assign in_ready_o = en_i && (state_q == StIdle);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    code_d  = code_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StDrive;
          code_d  = in_code_i;
          hold_d  = HoldLoad;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDrive: begin
        if (hold_q == '0) begin
          done_d = 1'b1;
          if (HasGap) begin
            state_d = StGap;
            gap_d   = GapLoad;
          end else begin
            state_d = StIdle;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Output register is fed from the next state so the line rises in the
  // cycle right after the accepting edge.
  onehot_decode_38 u_decode (
    .code_i   (code_d),
    .en_i     (state_d == StDrive),
    .onehot_o (onehot_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      hold_q   <= '0;
      gap_q    <= '0;
      code_q   <= '0;
      onehot_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      code_q   <= code_d;
      onehot_q <= onehot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_onehot_o = onehot_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign accept_cnt_o = cnt_q;

endmodule
